// File: rtl/pc_unit_pkg.sv
// Shared types, ISA constants and BTB helpers for the next-PC unit.
// ISA__* macros fall back to RV32I values when the build does not provide them.
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif
`ifndef ISA__OPCODE_WIDTH
`define ISA__OPCODE_WIDTH 7
`endif
`ifndef ISA__FUNCT3_WIDTH
`define ISA__FUNCT3_WIDTH 3
`endif
`ifndef ISA__INST_SIZE
`define ISA__INST_SIZE 4
`endif
`ifndef ISA__INST_LOAD_SIZE
`define ISA__INST_LOAD_SIZE 2
`endif

package pc_unit_pkg;

    localparam int XLEN       = `ISA__XLEN;
    localparam int OPC_W      = `ISA__OPCODE_WIDTH;
    localparam int F3_W       = `ISA__FUNCT3_WIDTH;
    localparam int INST_SIZE  = `ISA__INST_SIZE;
    localparam int ALIGN_BITS = `ISA__INST_LOAD_SIZE;

    localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);
    localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(7'b1101111);
    localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(7'b1100111);

    localparam logic [F3_W-1:0] F3_BEQ  = F3_W'(3'b000);
    localparam logic [F3_W-1:0] F3_BNE  = F3_W'(3'b001);
    localparam logic [F3_W-1:0] F3_BLT  = F3_W'(3'b100);
    localparam logic [F3_W-1:0] F3_BGE  = F3_W'(3'b101);
    localparam logic [F3_W-1:0] F3_BLTU = F3_W'(3'b110);
    localparam logic [F3_W-1:0] F3_BGEU = F3_W'(3'b111);

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag and target are held at full XLEN; unused upper tag bits stay zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
        logic            jump;
    } btb_entry_t;

    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_bits(input int depth, input int width);
        return width - $clog2(depth) - 2;
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: one prediction read
// port on the fetch PC and one read-modify-write update port from resolve.
module pc_unit_btb
    import pc_unit_pkg::*;
#(
    parameter int Width    = XLEN,
    parameter int BtbDepth = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] rd_pc,
    output logic             rd_taken,
    output logic [Width-1:0] rd_target,
    input  logic             upd_en,
    input  logic             upd_jump,
    input  logic             upd_taken,
    input  logic [Width-1:0] upd_pc,
    input  logic [Width-1:0] upd_target
);

    localparam int IdxW   = idx_bits(BtbDepth);
    localparam int TagLsb = IdxW + 2;

    btb_entry_t mem [BtbDepth];

    function automatic logic [XLEN-1:0] tag_of(input logic [Width-1:0] pc);
        return XLEN'(pc >> TagLsb);
    endfunction

    logic [IdxW-1:0] rd_idx;
    logic [IdxW-1:0] up_idx;
    btb_entry_t      rd_e;
    btb_entry_t      up_e;
    logic            rd_hit;
    logic            up_hit;
    logic            wr_en;
    btb_entry_t      wr_e;

    assign rd_idx = rd_pc[TagLsb-1:2];
    assign up_idx = upd_pc[TagLsb-1:2];
    assign rd_e   = mem[rd_idx];
    assign up_e   = mem[up_idx];

    assign rd_hit    = rd_e.valid && (rd_e.tag == tag_of(rd_pc));
    assign rd_taken  = rd_hit && (rd_e.jump || rd_e.ctr[1]);
    assign rd_target = rd_taken ? Width'(rd_e.target) : rd_pc + Width'(INST_SIZE);

    assign up_hit = up_e.valid && (up_e.tag == tag_of(upd_pc));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_en = 1'b0;
        wr_e  = up_e;
        if (upd_en) begin
            if (upd_jump) begin
                wr_en = 1'b1;
                wr_e  = '{valid: 1'b1, tag: tag_of(upd_pc), target: XLEN'(upd_target),
                          ctr: CTR_ST, jump: 1'b1};
            end else if (up_hit) begin
                wr_en    = 1'b1;
                wr_e.ctr = upd_taken ? ctr_inc(up_e.ctr) : ctr_dec(up_e.ctr);
                if (upd_taken) begin
                    wr_e.target = XLEN'(upd_target);
                end
            end else if (upd_taken) begin
                wr_en = 1'b1;
                wr_e  = '{valid: 1'b1, tag: tag_of(upd_pc), target: XLEN'(upd_target),
                          ctr: CTR_WT, jump: 1'b0};
            end
        end
    end

    // NOTE: the array is reset entry-by-entry (not a RAM macro) because a reset
    // must clear every valid bit and counter at once, discarding any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BtbDepth; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT, jump: 1'b0};
            end
        end else if (wr_en) begin
            mem[up_idx] <= wr_e;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Next-PC unit: fetch PC register, BTB prediction and branch/JAL/JALR resolve.
// Optional performance counters are built when PC_UNIT_PERF_EN is defined.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               Width       = XLEN,
    parameter logic [Width-1:0] ResetVector = '0,
    parameter int               BtbDepth    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ready,
    output logic [Width-1:0] fetch_pc,
    output logic             fetch_pred_taken,
    output logic [Width-1:0] fetch_pred_target,
    input  logic             res_valid,
    input  logic [Width-1:0] res_pc,
    input  logic [Width-1:0] res_a,
    input  logic [Width-1:0] res_b,
    input  logic [Width-1:0] res_imm,
    input  logic [OPC_W-1:0] res_opcode,
    input  logic [F3_W-1:0]  res_f3,
    input  logic [Width-1:0] res_pred_target,
    output logic             redirect,
    output logic [Width-1:0] redirect_pc,
    output logic             ialign,
    input  logic             trap_valid,
    input  logic [Width-1:0] trap_pc
`ifdef PC_UNIT_PERF_EN
    ,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts
`endif
);

    logic [Width-1:0] pc_q;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             is_cf;
    logic             br_taken;
    logic             lt_s;
    logic             lt_u;
    logic [Width-1:0] actual_next;
    logic [Width-1:0] jalr_sum;

    assign is_branch = (res_opcode == OPC_BRANCH);
    assign is_jal    = (res_opcode == OPC_JAL);
    assign is_jalr   = (res_opcode == OPC_JALR);
    assign is_cf     = is_branch || is_jal || is_jalr;

    assign lt_s = $signed(res_a) < $signed(res_b);
    assign lt_u = res_a < res_b;

    always_comb begin
        br_taken = 1'b0;
        case (res_f3)
            F3_BEQ:  br_taken = (res_a == res_b);
            F3_BNE:  br_taken = (res_a != res_b);
            F3_BLT:  br_taken = lt_s;
            F3_BGE:  br_taken = !lt_s;
            F3_BLTU: br_taken = lt_u;
            F3_BGEU: br_taken = !lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    assign jalr_sum = res_a + res_imm;

    always_comb begin
        actual_next = res_pc + Width'(INST_SIZE);
        if (is_jalr) begin
            actual_next = {jalr_sum[Width-1:1], 1'b0};
        end else if (is_jal || (is_branch && br_taken)) begin
            actual_next = res_pc + res_imm;
        end
    end

    // A misaligned target suppresses redirect and BTB training; the trap follows later.
    assign ialign      = res_valid && (|actual_next[ALIGN_BITS-1:0]);
    assign redirect    = res_valid && !ialign && (actual_next != res_pred_target);
    assign redirect_pc = actual_next;

    pc_unit_btb #(
        .Width    (Width),
        .BtbDepth (BtbDepth)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_pc      (pc_q),
        .rd_taken   (fetch_pred_taken),
        .rd_target  (fetch_pred_target),
        .upd_en     (res_valid && !ialign && is_cf),
        .upd_jump   (is_jal || is_jalr),
        .upd_taken  (br_taken),
        .upd_pc     (res_pc),
        .upd_target (actual_next)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ResetVector;
        end else if (trap_valid) begin
            pc_q <= trap_pc;
        end else if (redirect) begin
            pc_q <= actual_next;
        end else if (fetch_ready) begin
            pc_q <= fetch_pred_target;
        end
    end

    assign fetch_pc = pc_q;

`ifdef PC_UNIT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (res_valid && is_cf) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (redirect) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RV32I defaults, ResetVector 'h100).
// Perf counter checks are compiled in when PC_UNIT_PERF_EN is defined.
module tb_pc_unit;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    logic        clk;
    logic        rst_n;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_a;
    logic [31:0] res_b;
    logic [31:0] res_imm;
    logic [6:0]  res_opcode;
    logic [2:0]  res_f3;
    logic [31:0] res_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ialign;
    logic        trap_valid;
    logic [31:0] trap_pc;
`ifdef PC_UNIT_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    pc_unit #(
        .Width       (32),
        .ResetVector (32'h100),
        .BtbDepth    (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .res_valid         (res_valid),
        .res_pc            (res_pc),
        .res_a             (res_a),
        .res_b             (res_b),
        .res_imm           (res_imm),
        .res_opcode        (res_opcode),
        .res_f3            (res_f3),
        .res_pred_target   (res_pred_target),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .ialign            (ialign),
        .trap_valid        (trap_valid),
        .trap_pc           (trap_pc)
`ifdef PC_UNIT_PERF_EN
        ,
        .perf_branches     (perf_branches),
        .perf_mispredicts  (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pred);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_opcode      = op;
        res_f3          = f3;
        res_a           = a;
        res_b           = b;
        res_imm         = imm;
        res_pred_target = pred;
        #1;
    endtask

    task automatic clear_res();
        res_valid = 1'b0;
        #1;
    endtask

    task automatic steer(input logic [31:0] pc);
        trap_valid = 1'b1;
        trap_pc    = pc;
        tick();
        trap_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] seq_pc [3];
        seq_pc[0] = 32'h104;
        seq_pc[1] = 32'h108;
        seq_pc[2] = 32'h10C;

        rst_n = 1'b0; fetch_ready = 1'b0; res_valid = 1'b0;
        res_pc = '0; res_a = '0; res_b = '0; res_imm = '0;
        res_opcode = '0; res_f3 = '0; res_pred_target = '0;
        trap_valid = 1'b0; trap_pc = '0;

        // Reset and sequential fetch
        #12;
        check("rst_pc", fetch_pc, 32'h100);
        check("rst_pred", {31'd0, fetch_pred_taken}, 32'd0);
        check("rst_tgt", fetch_pred_target, 32'h104);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_pc", fetch_pc, seq_pc[i]);
            check("seq_pred", {31'd0, fetch_pred_taken}, 32'd0);
        end
        fetch_ready = 1'b0;

        // First-time taken branch
        resolve(32'h200, OP_BRANCH, 3'b000, 32'd5, 32'd5, 32'h40, 32'h204);
        check("beq_redir", {31'd0, redirect}, 32'd1);
        check("beq_rpc", redirect_pc, 32'h240);
        check("beq_ialign", {31'd0, ialign}, 32'd0);
        tick();
        clear_res();
        check("beq_fetch", fetch_pc, 32'h240);
        steer(32'h200);
        check("beq_pred", {31'd0, fetch_pred_taken}, 32'd1);
        check("beq_ptgt", fetch_pred_target, 32'h240);
        fetch_ready = 1'b1;
        tick();
        check("beq_follow", fetch_pc, 32'h240);
        fetch_ready = 1'b0;

        // Counter saturation on BLT at 0x300
        for (int i = 0; i < 3; i++) begin
            resolve(32'h300, OP_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h304);
            tick();
            clear_res();
        end
        resolve(32'h300, OP_BRANCH, 3'b100, 32'd5, 32'd1, 32'h80, 32'h380);
        check("blt_nt_redir", {31'd0, redirect}, 32'd1);
        check("blt_nt_rpc", redirect_pc, 32'h304);
        tick();
        clear_res();
        steer(32'h300);
        check("blt_sat_pred", {31'd0, fetch_pred_taken}, 32'd1);
        check("blt_sat_tgt", fetch_pred_target, 32'h380);
        resolve(32'h300, OP_BRANCH, 3'b100, 32'd5, 32'd1, 32'h80, 32'h380);
        tick();
        clear_res();
        steer(32'h300);
        check("blt_wnt_pred", {31'd0, fetch_pred_taken}, 32'd0);
        check("blt_wnt_tgt", fetch_pred_target, 32'h304);

        // Condition and arithmetic corners, checked combinationally
        resolve(32'h600, OP_BRANCH, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h604);
        check("bltu_rpc", redirect_pc, 32'h604);
        check("bltu_redir", {31'd0, redirect}, 32'd0);
        resolve(32'h600, OP_BRANCH, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h604);
        check("bge_rpc", redirect_pc, 32'h604);
        resolve(32'h600, OP_BRANCH, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h604);
        check("bgeu_rpc", redirect_pc, 32'h620);
        check("bgeu_redir", {31'd0, redirect}, 32'd1);
        resolve(32'h600, OP_BRANCH, 3'b010, 32'd7, 32'd7, 32'h20, 32'h604);
        check("bad_f3_rpc", redirect_pc, 32'h604);
        resolve(32'h600, OP_BRANCH, 3'b001, 32'd7, 32'd7, 32'h20, 32'h604);
        check("bne_eq_rpc", redirect_pc, 32'h604);
        resolve(32'h600, OP_BRANCH, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h604);
        check("neg_imm_rpc", redirect_pc, 32'h5F8);
        resolve(32'hFFFF_FFFC, OP_ADDI, 3'b000, 32'd0, 32'd0, 32'd0, 32'h0);
        check("wrap_rpc", redirect_pc, 32'h0);
        check("wrap_redir", {31'd0, redirect}, 32'd0);
        resolve(32'h880, OP_JALR, 3'b000, 32'h1000, 32'd0, 32'd5, 32'h884);
        check("jalr_bit0", redirect_pc, 32'h1004);
        check("jalr_al", {31'd0, ialign}, 32'd0);
        clear_res();

        // JALR misalignment
        resolve(32'h700, OP_JALR, 3'b000, 32'h1001, 32'd0, 32'd1, 32'h704);
        check("mis_ialign", {31'd0, ialign}, 32'd1);
        check("mis_redir", {31'd0, redirect}, 32'd0);
        check("mis_rpc", redirect_pc, 32'h1002);
        tick();
        clear_res();
        steer(32'h700);
        check("mis_nobtb", {31'd0, fetch_pred_taken}, 32'd0);

        // JAL training
        resolve(32'h800, OP_JAL, 3'b000, 32'd0, 32'd0, 32'h100, 32'h804);
        check("jal_rpc", redirect_pc, 32'h900);
        tick();
        clear_res();
        steer(32'h800);
        check("jal_pred", {31'd0, fetch_pred_taken}, 32'd1);
        check("jal_ptgt", fetch_pred_target, 32'h900);

        // Trap concurrent with redirect
        resolve(32'h400, OP_JAL, 3'b000, 32'd0, 32'd0, 32'h100, 32'h404);
        trap_valid = 1'b1;
        trap_pc    = 32'h80;
        #1;
        check("trap_redir", {31'd0, redirect}, 32'd1);
        check("trap_rpc", redirect_pc, 32'h500);
        tick();
        check("trap_fetch", fetch_pc, 32'h80);
        trap_valid = 1'b0;
        clear_res();
        steer(32'h400);
        check("trap_btb", fetch_pred_target, 32'h500);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", fetch_pc, 32'h100);
`ifdef PC_UNIT_PERF_EN
        check("mid_rst_pb", perf_branches, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        steer(32'h200);
        check("rst_btb_clr", {31'd0, fetch_pred_taken}, 32'd0);

        // Four branches, two of them mispredicted
        resolve(32'hA00, OP_BRANCH, 3'b000, 32'd1, 32'd1, 32'h10, 32'hA04);
        check("pb1_redir", {31'd0, redirect}, 32'd1);
        tick();
        resolve(32'hA00, OP_BRANCH, 3'b001, 32'd1, 32'd1, 32'h10, 32'hA04);
        check("pb2_redir", {31'd0, redirect}, 32'd0);
        tick();
        resolve(32'hA00, OP_BRANCH, 3'b000, 32'd1, 32'd2, 32'h10, 32'hA04);
        check("pb3_redir", {31'd0, redirect}, 32'd0);
        tick();
        resolve(32'hA00, OP_BRANCH, 3'b001, 32'd1, 32'd2, 32'h10, 32'hA04);
        check("pb4_redir", {31'd0, redirect}, 32'd1);
        tick();
        clear_res();
`ifdef PC_UNIT_PERF_EN
        check("perf_br", perf_branches, 32'd4);
        check("perf_mis", perf_mispredicts, 32'd2);
        rst_n = 1'b0;
        #1;
        check("perf_br_rst", perf_branches, 32'd0);
        check("perf_mis_rst", perf_mispredicts, 32'd0);
        rst_n = 1'b1;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Next-generation next-PC block. It owns the architectural fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- It resolves branch, JAL and JALR outcomes from execute and raises redirects on mispredicts.
- It sits between fetch and execute. It replaces the purely combinational next-PC calculation with predicted, registered sequencing.

Parameters:
- Width, `ISA__XLEN, datapath/PC width.
- ResetVector, 'h0 (Width bits), PC value loaded on reset.
- BtbDepth, 16, number of BTB entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_ready  input  1  fetch consumed fetch_pc this cycle; PC may advance.
- fetch_pc  output  Width  current fetch address (registered).
- fetch_pred_taken  output  1  BTB predicts taken for fetch_pc.
- fetch_pred_target  output  Width  predicted next PC for fetch_pc.
- res_valid  input  1  execute presents a resolved instruction.
- res_pc  input  Width  PC of the resolving instruction.
- res_a, res_b  input  Width each  rs1/rs2 operands.
- res_imm  input  Width  sign-extended immediate.
- res_opcode  input  `ISA__OPCODE_WIDTH  opcode.
- res_f3  input  `ISA__FUNCT3_WIDTH  funct3.
- res_pred_target  input  Width  fetch_pred_target carried down the pipeline with the instruction.
- redirect  output  1  mispredict; flush younger instructions.
- redirect_pc  output  Width  correct next PC.
- ialign  output  1  resolved next PC is misaligned.
- trap_valid  input  1  trap/debug entry.
- trap_pc  input  Width  trap target.

Behaviour:
- **Reset (asynchronous):** pc_q = ResetVector. All BTB valid bits = 0. All counters = 2'b01 (weakly not-taken).
- **Actual next PC (combinational, from res_\*):**
  - Branch taken or JAL: res_pc + res_imm.
  - JALR: (res_a + res_imm) with bit 0 cleared.
  - Otherwise: res_pc + `ISA__INST_SIZE.
  - Branch conditions per f3 (BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned). Unknown f3 = not taken.
  - All adds are mod 2^Width.
- **ialign:** res_valid && actual next PC has any nonzero bit in [`ISA__INST_LOAD_SIZE-1:0].
- **redirect:** res_valid && !ialign && actual next PC != res_pred_target. redirect_pc = actual next PC.
  - Both are combinational, same cycle as res_valid.
  - When ialign=1: redirect=0 and the BTB is not updated; the trap arrives later via trap_valid.
- **PC register update priority:**
  1. trap_valid: pc_q <= trap_pc.
  2. redirect: pc_q <= redirect_pc.
  3. fetch_ready: pc_q <= fetch_pred_target.
  4. Otherwise hold.
- **BTB indexing:** idx = pc[log2(BtbDepth)+1:2]; tag = pc[Width-1:log2(BtbDepth)+2]. Entry fields: valid, tag, target, ctr[1:0], jump.
- **Prediction (combinational from pc_q):**
  - hit = valid && tag match.
  - fetch_pred_taken = hit && (jump || ctr[1]).
  - fetch_pred_target = fetch_pred_taken ? target : pc_q + `ISA__INST_SIZE.
- **BTB update:** registered, effective on the next cycle. Condition: res_valid && !ialign && opcode is BRANCH, JAL or JALR.
  - JAL/JALR: write valid, tag, target = actual next PC, jump=1, ctr=2'b11.
  - Branch hit, taken: ctr saturating increment, target refreshed.
  - Branch hit, not taken: ctr saturating decrement.
  - Branch miss, taken: allocate entry with ctr=2'b10, jump=0.
  - Branch miss, not taken: no write.
- **Same-cycle read/write of the same index:** prediction uses pre-update contents.
- **trap_valid concurrent with redirect:** the trap wins for the PC. The BTB update from res_\* still occurs.
- **Reset mid-operation:** everything returns to reset state immediately. No partial BTB writes survive.

Optional Feature:
- Macro: PC_UNIT_PERF_EN.
- **Defined:**
  - Adds outputs perf_branches and perf_mispredicts, 32 bits each. Both reset to 0 and wrap at 2^32.
  - perf_branches increments on every res_valid control-flow instruction (BRANCH/JAL/JALR).
  - perf_mispredicts increments on every cycle with redirect=1.
- **Undefined:** these ports and counters do not exist.

Decomposition:
- Package pc_unit_pkg:
  - btb_entry_t struct (valid, tag, target, ctr, jump).
  - Counter encoding constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - Index/tag width functions of BtbDepth and Width.
- Sub-module pc_unit_btb: storage array, read port on pc_q, update port driven by the resolve logic.
- Resolve/condition logic stays in pc_unit.

Test Plan:
1. **Reset and sequential fetch:** reset with ResetVector='h100, fetch_ready=1 for 3 cycles -> fetch_pc 100, 104, 108, 10C; fetch_pred_taken=0.
2. **First-time branch:** res_pc=0x200, BEQ a=b=5, imm=0x40, res_pred_target=0x204 -> redirect=1, redirect_pc=0x240.
   - Next cycle fetch_pc=0x240. A later fetch of 0x200 predicts taken to 0x240.
3. **Counter saturation:** train BLT at 0x300 taken 3 times, then not taken once -> still predicts taken (ctr 11->10). A second not-taken -> predicts 0x304.
4. **JALR misalignment:** a=0x1001, imm=1 -> target 0x1002, ialign=1, redirect=0, BTB unchanged.
5. **Concurrent trap and redirect:** redirect to 0x500 with trap_valid, trap_pc=0x80 -> next fetch_pc=0x80.
6. **Perf counters (PC_UNIT_PERF_EN defined):** 4 branches including 2 mispredicts -> perf_branches=4, perf_mispredicts=2. Reset -> both 0.
